// File: rtl/inst_rom_resp.sv
// Instruction-memory responder: word array with fixed access latency.
// Optional INST_ROM_ENDIAN_SWAP_EN byte-reverses served words.
module inst_rom_resp #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_i,
    input  logic [31:0]       addr_i,
    output logic [31:0]       inst_o,
    output logic              ready_o,
    output logic              err_o,
    input  logic              load_we_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [31:0]       load_data_i
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

    logic [31:0] mem [2**ADDR_W];

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] addr_q;

    logic [31:0] rd_addr;
    logic [31:0] rd_word;
    logic        rd_bad;
    logic [31:0] rd_inst;

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
    endfunction

    function automatic logic [31:0] fmt(input logic [31:0] w);
`ifdef INST_ROM_ENDIAN_SWAP_EN
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
        return w;
`endif
    endfunction

    // Zero-wait responses come straight from the request; otherwise latched.
    always_comb begin
        rd_addr = (state == WAIT) ? addr_q : addr_i;
        rd_word = mem[rd_addr[ADDR_W+1:2]];
        rd_bad  = addr_bad(rd_addr);
        rd_inst = rd_bad ? 32'd0 : fmt(rd_word);
    end

    // Preload port; read in the FSM block sees the pre-write word.
    always_ff @(posedge clk) begin
        if (load_we_i) begin
            mem[load_addr_i] <= load_data_i;
        end
    end

    // Request sequencing with registered response outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= 32'd0;
            inst_o  <= 32'd0;
            ready_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            ready_o <= 1'b0;
            err_o   <= 1'b0;
            case (state)
                IDLE, RESP: begin
                    if (ce_i) begin
                        addr_q <= addr_i;
                        cnt    <= WAIT_N;
                        if (WAIT_CYCLES > 0) begin
                            state <= WAIT;
                        end else begin
                            state   <= RESP;
                            inst_o  <= rd_inst;
                            ready_o <= 1'b1;
                            err_o   <= rd_bad;
                        end
                    end else begin
                        state <= IDLE;
                        if (state == IDLE) begin
                            inst_o <= 32'd0;
                        end
                    end
                end
                WAIT: begin
                    if (!ce_i) begin
                        state  <= IDLE;
                        cnt    <= 4'd0;
                        inst_o <= 32'd0;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state   <= RESP;
                            inst_o  <= rd_inst;
                            ready_o <= 1'b1;
                            err_o   <= rd_bad;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/inst_rom_resp.md
Name: inst_rom_resp

Overview:
Instruction-memory responder: the memory end of the core's fetch interface (PC byte address plus fetch enable out, 32-bit instruction back). It serves fetch requests from a word array with a parameterised access latency and signals completion with a one-cycle ready pulse. It also owns a preload write port used by benches and boot logic. It sits outside the CPU top and connects to the instruction-fetch port.

Parameters:
ADDR_W, 10, word-index width; array depth = 2**ADDR_W words
WAIT_CYCLES, 0, extra access cycles beyond the minimum 1-cycle latency; legal range 0..15

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
ce_i  in  1  fetch enable from core
addr_i  in  32  fetch byte address
inst_o  out  32  fetched instruction, registered
ready_o  out  1  one-cycle pulse; inst_o valid this cycle
err_o  out  1  one-cycle pulse with ready_o; request was misaligned or out of range
load_we_i  in  1  preload write enable
load_addr_i  in  ADDR_W  preload word index
load_data_i  in  32  preload data

Behaviour:
- Reset (rst=0, async): state IDLE; wait counter 0; latched address 0; inst_o=0; ready_o=0; err_o=0. Array contents are not cleared.
- Word index = addr_i[ADDR_W+1:2].
- misaligned = addr_i[1:0]!=0.
- out_of_range = addr_i[31:ADDR_W+2]!=0.
- FSM states IDLE, WAIT, RESP.
- IDLE:
  - ce_i=1 at an edge: latch addr_i and set counter=WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
  - ce_i=0: stay IDLE.
- WAIT:
  - Counter decrements each cycle.
  - On the edge where counter==1, go to RESP.
- Entering RESP (a single edge):
  - Read the array at the latched index into inst_o and assert ready_o.
  - If the latched address was misaligned or out of range: inst_o=0 (NOP), err_o=1, no array read.
- RESP lasts one cycle:
  - ready_o/err_o drop the next cycle.
  - inst_o holds until the next response.
  - From RESP: if ce_i=1, latch a new request immediately, same rules as IDLE. This gives back-to-back service: one response every WAIT_CYCLES+1 cycles. Otherwise go IDLE.
- Latency: request sampled at edge N gives ready_o high during the cycle after edge N+WAIT_CYCLES+1−1, i.e. WAIT_CYCLES+1 cycles after sampling.
- Address changes during WAIT are ignored; the latched address is served.
- ce_i=0 sampled during WAIT: abort, go IDLE, no ready_o, inst_o cleared to 0 on that edge.
- ce_i=0 sampled in IDLE: inst_o cleared to 0, matching the core's expectation of NOP when fetch is disabled.
- Preload:
  - load_we_i=1 writes load_data_i to the array at load_addr_i on the edge. This is independent of the FSM.
  - A write and a response read to the same word on the same edge return the OLD data (read-before-write).
- Async reset asserted mid-WAIT: immediate return to reset values; the pending request is dropped with no ready.

Optional Feature:
- Macro INST_ROM_ENDIAN_SWAP_EN.
- Defined: inst_o = byte-reversed array word ({w[7:0],w[15:8],w[23:16],w[31:24]}) for valid responses, so little-endian image files can drive the big-endian core. The error NOP stays 0.
- Undefined: array word passed through unchanged.

Test Plan:
- WAIT_CYCLES=0; preload word 3 = 0x3401_0020; ce_i=1, addr_i=0x0000_000C → ready_o=1 exactly 1 cycle after sampling, inst_o=0x3401_0020, err_o=0.
- WAIT_CYCLES=3; ce_i held 1 with addr_i stepping 0x0,0x4,0x8 per response → ready_o every 4 cycles; inst_o equals words 0,1,2 in order.
- WAIT_CYCLES=3; address changed from 0x4 to 0x8 during WAIT → response carries word 1. ce_i dropped at the second WAIT cycle → no ready_o; inst_o=0 next edge; FSM returns to IDLE.
- addr_i=0x0000_0006 → inst_o=0, ready_o=1, err_o=1. With ADDR_W=10, addr_i=0x0000_1000 → same error response.
- load_we_i writes 0xDEAD_BEEF to word 5 on the same edge a response reads word 5 (old 0x1111_1111) → inst_o=0x1111_1111; a following fetch of word 5 returns 0xDEAD_BEEF.
- rst driven low asynchronously mid-WAIT → inst_o, ready_o and err_o go to 0 immediately; no ready pulse after release. With INST_ROM_ENDIAN_SWAP_EN defined, word 0x1122_3344 → inst_o=0x4433_2211.
